spi_reg_slave: RTL and testbench
================================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter DATA_W, default 8, SPI word width in bits; minimum 4.
REQ-002 Parameter CPOL, default 0, idle SCK level.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter DEVID, default 8'hE5, read-only value of register 0.
REQ-005 Derived: ADDR_W = DATA_W-2; NUM_REGS = 2**ADDR_W.
REQ-006 CLK  in  1  system clock; one clock only, all logic on posedge CLK.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 SCK  in  1  SPI clock, asynchronous to CLK.
REQ-009 MOSI  in  1  SPI data in, MSB first.
REQ-010 CS  in  1  chip select, active low.
REQ-011 MISO  out  1  SPI data out, MSB first.
REQ-012 MISO_OE  out  1  MISO drive enable, 1 only while CS is low (synchronised).
REQ-013 LOC_WE  in  1  local register write strobe.
REQ-014 LOC_ADDR  in  ADDR_W  local write address.
REQ-015 LOC_WDATA  in  DATA_W  local write data.
REQ-016 WR_VALID  out  1  one-CLK pulse per completed SPI register write.
REQ-017 WR_ADDR  out  ADDR_W  address of that write.
REQ-018 WR_DATA  out  DATA_W  data of that write.
REQ-019 BUSY  out  1  synchronised CS active.

Function
REQ-020 SCK, MOSI and CS shall each pass through a 2-flop synchroniser; SCK edges are detected from the synchronised signal.
REQ-021 Correct operation requires each SCK half-period and the CS-to-first-edge time to be at least 5 CLK periods; no behaviour is required below this limit.
REQ-022 Leading edge is rising when CPOL=0 and falling when CPOL=1; the sample edge is leading when CPHA=0 and trailing when CPHA=1; the shift edge is the other edge.
REQ-023 State machine: IDLE -> CMD on synchronised CS fall; CMD -> DATA after DATA_W sample edges; DATA stays in DATA until CS rises; any state -> IDLE on synchronised CS rise.
REQ-024 Command word: bit DATA_W-1 = R/W (1 = read), bit DATA_W-2 = MB (multi-byte), bits ADDR_W-1:0 = start address.
REQ-025 The bit counter counts sample edges modulo DATA_W; a word completes on the DATA_W-th sample.
REQ-026 MISO shall be 0 throughout the command word.
REQ-027 Read: within 2 CLK of command completion, reg[addr] loads into the TX shift register, and its MSB is on MISO before the next shift edge (CPHA=0) or before the first sample edge of the data word (CPHA=1).
REQ-028 Write: on completion of each data word, reg[addr] updates and WR_VALID pulses for 1 CLK with WR_ADDR/WR_DATA, 1 CLK after the completing sample edge is detected.
REQ-029 Register 0 is read-only: SPI and local writes to address 0 are ignored, with no WR_VALID.
REQ-030 MB=1: address increments after each data word, wrapping NUM_REGS-1 -> 0 (0 is then read-only).
REQ-031 MB=0: only the first data word is acted on; further words are ignored, MISO=0, no WR_VALID.
REQ-032 LOC_WE writes LOC_WDATA to reg[LOC_ADDR] on the same CLK edge; if an SPI write commits to the same address in the same cycle, the SPI write wins; different addresses both commit.
REQ-033 Read data is captured at load time; local writes during an in-flight word do not alter the shifted bits.
REQ-034 CS rise mid-word: the partial word is discarded with no write and no WR_VALID; state returns to IDLE and the counter clears.
REQ-035 When synchronised CS is high, MISO=0 and MISO_OE=0.

Reset
REQ-036 While RST_N=0: state IDLE, counter 0, shift registers 0, MISO=0, MISO_OE=0, WR_VALID=0, WR_ADDR=0, WR_DATA=0, BUSY=0, reg[0]=DEVID, all other registers 0.
REQ-037 Reset asserted mid-transaction aborts the transaction with no write; after release, the block waits for a fresh CS fall, ignoring a CS that is already low.

Verification
REQ-038 Defaults, CS low, send 0x80 then 8 clocks -> MISO returns 0xE5, no WR_VALID.
REQ-039 Send 0x45, 0xAA, 0x55 (write, MB, addr 5) -> WR_VALID pulses (5,0xAA) then (6,0x55); a following read burst from 5 returns 0xAA, 0x55.
REQ-040 Send 0x7F, 0x11, 0x22 (MB write from 63) -> reg63=0x11, write to 0 ignored, reg0 still 0xE5, exactly one WR_VALID.
REQ-041 Send 0x03 then 4 bits and raise CS -> no WR_VALID, reg3 unchanged; the next transaction decodes correctly.
REQ-042 LOC_WE to addr 9 in the same CLK as the SPI write (9,0x33), with LOC_WDATA=0x77 -> reg9=0x33; repeat with CPOL=1/CPHA=1 -> identical results.
REQ-043 Pulse RST_N low mid-read -> all outputs 0 within the reset; a new read of 0 after reset returns 0xE5.

Source files
------------

// File: rtl/spi_reg_slave.sv
// SPI register slave: synchronised SPI front end, command/data FSM and a
// register file with a local write port. Register 0 is the read-only DEVID.
module spi_reg_slave #(
  parameter int                DATA_W = 8,
  parameter int                CPOL   = 0,
  parameter int                CPHA   = 0,
  parameter logic [DATA_W-1:0] DEVID  = DATA_W'(8'hE5)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              CS,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic              LOC_WE,
  input  logic [DATA_W-3:0] LOC_ADDR,
  input  logic [DATA_W-1:0] LOC_WDATA,
  output logic              WR_VALID,
  output logic [DATA_W-3:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              BUSY
);
  localparam int ADDR_W   = DATA_W - 2;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [2:0]       SCK_IDLE = (CPOL != 0) ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;
  state_e state_q, state_d;

  logic [2:0]        sck_s_q, sck_s_d;
  logic [1:0]        mosi_s_q, mosi_s_d;
  logic [1:0]        cs_s_q, cs_s_d;
  logic [1:0]        sync_vld_q, sync_vld_d;
  logic              arm_q, arm_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              rw_q, rw_d;
  logic              mb_q, mb_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              cs_act, sck_rise, sck_fall, samp_edge, shift_edge;
  logic              word_done, active, cmd_done, data_done, spi_we;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] cmd_addr, addr_inc;

  // Synchronisers and edge detection
  always_comb begin
    sck_s_d    = {sck_s_q[1:0], SCK};
    mosi_s_d   = {mosi_s_q[0], MOSI};
    cs_s_d     = {cs_s_q[0], CS};
    sync_vld_d = {sync_vld_q[0], 1'b1};
    // Only a CS seen high after reset may open a transaction
    arm_d      = arm_q | (sync_vld_q[1] & cs_s_q[1]);
  end

  assign cs_act     = ~cs_s_q[1];
  assign sck_rise   = sck_s_q[1] & ~sck_s_q[2];
  assign sck_fall   = ~sck_s_q[1] & sck_s_q[2];
  assign samp_edge  = ((CPOL == 0) == (CPHA == 0)) ? sck_rise : sck_fall;
  assign shift_edge = ((CPOL == 0) == (CPHA == 0)) ? sck_fall : sck_rise;
  assign word_done  = samp_edge && (bit_cnt_q == LAST_BIT);
  assign word       = {rx_q[DATA_W-2:0], mosi_s_q[1]};
  assign cmd_addr   = word[ADDR_W-1:0];
  assign addr_inc   = addr_q + ADDR_W'(1);

  // FSM: state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (!cs_act) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm_q) state_d = CMD;
        CMD:     if (word_done) state_d = DATA;
        DATA:    state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    active    = 1'b0;
    cmd_done  = 1'b0;
    data_done = 1'b0;
    if (cs_act && state_q != IDLE) begin
      active    = 1'b1;
      cmd_done  = (state_q == CMD) && word_done;
      data_done = (state_q == DATA) && word_done;
    end
  end

  // Shift registers, command decode and address tracking
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    mb_d      = mb_q;
    first_d   = first_q;
    addr_d    = addr_q;
    spi_we    = 1'b0;
    if (!active) begin
      bit_cnt_d = '0;
      rx_d      = '0;
      tx_d      = '0;
    end else begin
      if (samp_edge) begin
        rx_d      = word;
        bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
      end
      // The MSB of each word is placed by the load, so the first shift edge is skipped
      if (shift_edge && bit_cnt_q != '0) tx_d = {tx_q[DATA_W-2:0], 1'b0};
      if (cmd_done) begin
        rw_d    = word[DATA_W-1];
        mb_d    = word[DATA_W-2];
        addr_d  = cmd_addr;
        first_d = 1'b1;
        tx_d    = word[DATA_W-1] ? regs_q[cmd_addr] : '0;
      end
      if (data_done) begin
        first_d = 1'b0;
        if (mb_q) addr_d = addr_inc;
        spi_we  = !rw_q && (mb_q || first_q) && (addr_q != '0);
        tx_d    = (rw_q && mb_q) ? regs_q[addr_inc] : '0;
      end
    end
  end

  // Register file: SPI write is applied last so it wins an address collision
  always_comb begin
    regs_d = regs_q;
    if (LOC_WE && LOC_ADDR != '0) regs_d[LOC_ADDR] = LOC_WDATA;
    if (spi_we) regs_d[addr_q] = word;
    regs_d[0]  = DEVID;
    wr_valid_d = spi_we;
    wr_addr_d  = spi_we ? addr_q : wr_addr_q;
    wr_data_d  = spi_we ? word : wr_data_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sck_s_q    <= SCK_IDLE;
      mosi_s_q   <= '0;
      cs_s_q     <= '1;
      sync_vld_q <= '0;
      arm_q      <= 1'b0;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      mb_q       <= 1'b0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == 0) ? DEVID : '0;
    end else begin
      sck_s_q    <= sck_s_d;
      mosi_s_q   <= mosi_s_d;
      cs_s_q     <= cs_s_d;
      sync_vld_q <= sync_vld_d;
      arm_q      <= arm_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      mb_q       <= mb_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign MISO     = tx_q[DATA_W-1] & cs_act;
  assign MISO_OE  = cs_act;
  assign BUSY     = cs_act;
  assign WR_VALID = wr_valid_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: one mode-0 and one mode-3 instance,
// SPI master driven at CLK negedges, write pulses logged by a monitor.
module tb_spi_reg_slave;
  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       sck0 = 1'b0, sck3 = 1'b1, cs0 = 1'b1, cs3 = 1'b1, mosi = 1'b0;
  logic       loc_we = 1'b0;
  logic [5:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic       miso0, miso3, oe0, oe3, wv0, wv3, busy0, busy3;
  logic [5:0] wa0, wa3;
  logic [7:0] wd0, wd3;
  int         n_cmp = 0, n_err = 0, m = 0, nw = 0;
  logic       loc_arm = 1'b0;
  logic [13:0] log0[$], log3[$];
  logic [7:0] r;

  always #5 CLK = ~CLK;

  spi_reg_slave #(.DATA_W(8), .CPOL(0), .CPHA(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .SCK(sck0), .MOSI(mosi), .CS(cs0),
    .MISO(miso0), .MISO_OE(oe0), .LOC_WE(loc_we), .LOC_ADDR(loc_addr),
    .LOC_WDATA(loc_wdata), .WR_VALID(wv0), .WR_ADDR(wa0), .WR_DATA(wd0),
    .BUSY(busy0));

  spi_reg_slave #(.DATA_W(8), .CPOL(1), .CPHA(1)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .SCK(sck3), .MOSI(mosi), .CS(cs3),
    .MISO(miso3), .MISO_OE(oe3), .LOC_WE(loc_we), .LOC_ADDR(loc_addr),
    .LOC_WDATA(loc_wdata), .WR_VALID(wv3), .WR_ADDR(wa3), .WR_DATA(wd3),
    .BUSY(busy3));

  always @(negedge CLK) begin
    if (wv0) log0.push_back({wa0, wd0});
    if (wv3) log3.push_back({wa3, wd3});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] logent(input int md, input int i);
    if (md == 0) return (i < log0.size()) ? log0[i] : 14'h3FFF;
    return (i < log3.size()) ? log3[i] : 14'h3FFF;
  endfunction

  function automatic int nwr();
    return (m == 0) ? log0.size() : log3.size();
  endfunction

  // Half SCK period; releases an armed local write right after the SPI commit
  task automatic half();
    repeat (8) begin
      @(negedge CLK);
      if (loc_arm && ((m == 0) ? wv0 : wv3)) begin
        loc_we  = 1'b0;
        loc_arm = 1'b0;
      end
    end
  endtask

  task automatic cs_low();
    if (m == 0) cs0 = 1'b0; else cs3 = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    if (m == 0) cs0 = 1'b1; else cs3 = 1'b1;
    half();
    half();
  endtask

  task automatic xbit(input logic b, output logic rb);
    if (m == 0) begin
      mosi = b; half(); sck0 = 1'b1; rb = miso0; half(); sck0 = 1'b0;
    end else begin
      sck3 = 1'b0; mosi = b; half(); sck3 = 1'b1; rb = miso3; half();
    end
  endtask

  task automatic xbyte(input logic [7:0] t, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) xbit(t[i], rx[i]);
  endtask

  task automatic rd1(input logic [7:0] cmd, output logic [7:0] d);
    logic [7:0] c;
    cs_low(); xbyte(cmd, c); xbyte(8'h00, d); cs_high();
  endtask

  // SPI write of one word with a local write held until the SPI commit
  task automatic wr_loc(input logic [7:0] cmd, input logic [7:0] dat,
                        input logic [5:0] la, input logic [7:0] ld);
    logic [7:0] c;
    cs_low(); xbyte(cmd, c);
    loc_addr = la; loc_wdata = ld;
    for (int i = 7; i >= 1; i--) xbit(dat[i], c[i]);
    loc_we = 1'b1; loc_arm = 1'b1;
    xbit(dat[0], c[0]);
    cs_high();
  endtask

  initial begin
    repeat (4) @(negedge CLK);
    chk("rst_miso", miso0, 0);  chk("rst_oe", oe0, 0);   chk("rst_busy", busy0, 0);
    chk("rst_wv", wv0, 0);      chk("rst_wa", wa0, 0);   chk("rst_wd", wd0, 0);
    chk("rst_oe3", oe3, 0);     chk("rst_busy3", busy3, 0);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    m = 0;
    cs_low();
    chk("busy_cs_low", busy0, 1); chk("oe_cs_low", oe0, 1);
    xbyte(8'h80, r); chk("cmd_miso_zero", r, 8'h00);
    xbyte(8'h00, r); chk("rd_devid", r, 8'hE5);
    cs_high();
    chk("oe_cs_high", oe0, 0); chk("busy_cs_high", busy0, 0);
    chk("rd_no_wr", nwr(), 0);

    cs_low(); xbyte(8'h45, r); xbyte(8'hAA, r); xbyte(8'h55, r); cs_high();
    chk("mb_nwr", nwr(), 2);
    chk("mb_wr0", logent(0, 0), {6'd5, 8'hAA});
    chk("mb_wr1", logent(0, 1), {6'd6, 8'h55});
    cs_low(); xbyte(8'hC5, r); chk("mb_rd_cmd", r, 8'h00);
    xbyte(8'h00, r); chk("mb_rd0", r, 8'hAA);
    xbyte(8'h00, r); chk("mb_rd1", r, 8'h55);
    cs_high();

    cs_low(); xbyte(8'h7F, r); xbyte(8'h11, r); xbyte(8'h22, r); cs_high();
    chk("wrap_nwr", nwr(), 3);
    chk("wrap_wr", logent(0, 2), {6'd63, 8'h11});
    rd1(8'hBF, r); chk("wrap_rd63", r, 8'h11);
    rd1(8'h80, r); chk("wrap_rd0", r, 8'hE5);

    cs_low(); xbyte(8'h03, r);
    for (int i = 0; i < 4; i++) xbit(1'b1, r[i]);
    cs_high();
    chk("part_nwr", nwr(), 3);
    rd1(8'h83, r); chk("part_rd3", r, 8'h00);
    cs_low(); xbyte(8'h03, r); xbyte(8'h3A, r); cs_high();
    chk("part_next_nwr", nwr(), 4);
    chk("part_next_wr", logent(0, 3), {6'd3, 8'h3A});

    cs_low(); xbyte(8'h0A, r); xbyte(8'h5A, r); xbyte(8'h6B, r); cs_high();
    chk("sb_nwr", nwr(), 5);
    chk("sb_wr", logent(0, 4), {6'd10, 8'h5A});
    cs_low(); xbyte(8'h8A, r); xbyte(8'h00, r); chk("sb_rd0", r, 8'h5A);
    xbyte(8'h00, r); chk("sb_rd1_zero", r, 8'h00);
    cs_high();
    rd1(8'h8B, r); chk("sb_rd11", r, 8'h00);

    @(negedge CLK); loc_we = 1'b1; loc_addr = 6'd0;  loc_wdata = 8'h12;
    @(negedge CLK); loc_addr = 6'd12; loc_wdata = 8'h3C;
    @(negedge CLK); loc_we = 1'b0;
    rd1(8'h80, r); chk("loc_rd0", r, 8'hE5);
    rd1(8'h8C, r); chk("loc_rd12", r, 8'h3C);
    chk("loc_nwr", nwr(), 5);

    cs_low(); xbyte(8'h8C, r);
    xbit(1'b0, r[7]); xbit(1'b0, r[6]);
    @(negedge CLK); loc_we = 1'b1; loc_addr = 6'd12; loc_wdata = 8'hC3;
    @(negedge CLK); loc_we = 1'b0;
    for (int i = 5; i >= 0; i--) xbit(1'b0, r[i]);
    cs_high();
    chk("capt_rd", r, 8'h3C);
    rd1(8'h8C, r); chk("capt_rd_new", r, 8'hC3);

    wr_loc(8'h09, 8'h33, 6'd9, 8'h77);
    chk("coll_we_drop", loc_we, 0);
    chk("coll_nwr", nwr(), 6);
    chk("coll_wr", logent(0, 5), {6'd9, 8'h33});
    rd1(8'h89, r); chk("coll_rd9", r, 8'h33);
    wr_loc(8'h0E, 8'h21, 6'd15, 8'h99);
    chk("both_nwr", nwr(), 7);
    rd1(8'h8E, r); chk("both_rd14", r, 8'h21);
    rd1(8'h8F, r); chk("both_rd15", r, 8'h99);

    m = 3;
    rd1(8'h80, r); chk("m3_devid", r, 8'hE5);
    wr_loc(8'h09, 8'h33, 6'd9, 8'h77);
    chk("m3_we_drop", loc_we, 0);
    chk("m3_nwr", nwr(), 1);
    chk("m3_wr", logent(3, 0), {6'd9, 8'h33});
    rd1(8'h89, r); chk("m3_rd9", r, 8'h33);
    rd1(8'h8C, r); chk("m3_rd12", r, 8'hC3);

    m = 0;
    cs_low(); xbyte(8'h85, r);
    xbit(1'b0, r[7]); xbit(1'b0, r[6]);
    repeat (4) @(negedge CLK);
    chk("pre_rst_miso", miso0, 1);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mid_rst_miso", miso0, 0); chk("mid_rst_oe", oe0, 0);
    chk("mid_rst_busy", busy0, 0); chk("mid_rst_wv", wv0, 0);
    chk("mid_rst_wa", wa0, 0);     chk("mid_rst_wd", wd0, 0);
    RST_N = 1'b1;
    half();
    nw = nwr();
    xbyte(8'h0D, r); xbyte(8'h44, r);
    cs_high();
    chk("stale_cs_nwr", nwr(), nw);
    rd1(8'h8D, r); chk("stale_cs_rd13", r, 8'h00);
    rd1(8'h80, r); chk("post_rst_devid", r, 8'hE5);
    rd1(8'h85, r); chk("post_rst_rd5", r, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
